// File: rtl/stacker_pkg.sv
// Shared definitions for the block-stacking game: colour codes, state encoding,
// playfield geometry and small helper functions.
package stacker_pkg;

  localparam logic [10:0]        WIDTH     = 11'd100;
  localparam logic [10:0]        HEIGHT    = 11'd20;
  localparam logic [10:0]        BASE_Y    = 11'd400;
  localparam logic [9:0]         SPAWN_Y   = 10'd20;
  localparam logic [10:0]        FALL_STEP = 11'd4;
  localparam logic signed [10:0] CATCH_TOL = 11'sd50;
  localparam logic [1:0]         MAX_MISS  = 2'd3;
  localparam logic [3:0]         MAX_H     = 4'd15;
  localparam logic [7:0]         LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    CLR_NONE = 2'b00,
    CLR_G    = 2'b01,
    CLR_R    = 2'b10,
    CLR_B    = 2'b11
  } clr_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPAWN = 3'd1,
    ST_FALL  = 3'd2,
    ST_LAND  = 3'd3,
    ST_OVER  = 3'd4,
    ST_FULL  = 3'd5
  } state_e;

  // A zero random code would make an invisible block, so it is drawn red instead.
  function automatic logic [1:0] spawn_clr(input logic [7:0] r);
    logic [1:0] c;
    if (r[1:0] == 2'b00) begin
      c = CLR_R;
    end else begin
      c = r[1:0];
    end
    return c;
  endfunction

  function automatic logic [10:0] land_y(input logic [3:0] h);
    return BASE_Y - (({7'd0, h} + 11'd1) * HEIGHT);
  endfunction

endpackage

// File: rtl/stack_engine_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
module lfsr8
  import stacker_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  logic [7:0] q_r;

  // shift register, advances every clock
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= LFSR_SEED;
    end else begin
      q_r <= {q_r[6:0], q_r[7] ^ q_r[5] ^ q_r[4] ^ q_r[3]};
    end
  end

  assign q = q_r;

endmodule

// File: rtl/stack_engine.sv
// Game-state producer for the stacking game: spawns, drops and lands blocks.
// Optional macro STACK_SPEEDUP_EN: fall step grows by one per four stacked blocks.
module stack_engine
  import stacker_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic [9:0]  pos_x,
  output logic [31:0] colors,
  output logic [9:0]  fall_x,
  output logic [9:0]  fall_y,
  output logic [1:0]  fall_clr,
  output logic [3:0]  height,
  output logic [1:0]  misses,
  output logic        game_over,
  output logic        win
);

  state_e      state_r, state_s;
  logic [31:0] colors_r, colors_s;
  logic [9:0]  fall_x_r, fall_x_s;
  logic [9:0]  fall_y_r, fall_y_s;
  logic [1:0]  fall_clr_r, fall_clr_s;
  logic [3:0]  height_r, height_s;
  logic [1:0]  misses_r, misses_s;
  logic        game_over_r, game_over_s;
  logic        win_r, win_s;

  logic [7:0]         lfsr_q_s;
  logic [10:0]        step_s, ny_s, land_y_s;
  logic signed [10:0] diff_s, dist_s;
  logic               catch_s;
  logic [3:0]         slot_s;

  lfsr8 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q_s)
  );

  // fall arithmetic and catch test
  always_comb begin
`ifdef STACK_SPEEDUP_EN
    step_s = FALL_STEP + {9'd0, height_r[3:2]};
`else
    step_s = FALL_STEP;
`endif
    ny_s     = {1'b0, fall_y_r} + step_s;
    land_y_s = land_y(height_r);
    diff_s   = $signed({1'b0, fall_x_r}) - $signed({1'b0, pos_x});
    if (diff_s[10]) begin
      dist_s = -diff_s;
    end else begin
      dist_s = diff_s;
    end
    catch_s = (dist_s < CATCH_TOL);
    slot_s  = height_r + 4'd1;
  end

  // next-state and next-output logic
  always_comb begin
    state_s     = state_r;
    colors_s    = colors_r;
    fall_x_s    = fall_x_r;
    fall_y_s    = fall_y_r;
    fall_clr_s  = fall_clr_r;
    height_s    = height_r;
    misses_s    = misses_r;
    game_over_s = game_over_r;
    win_s       = win_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_SPAWN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SPAWN: begin
        fall_x_s   = {1'b0, lfsr_q_s, 1'b0};
        fall_clr_s = spawn_clr(lfsr_q_s);
        fall_y_s   = SPAWN_Y;
        state_s    = ST_FALL;
      end
      ST_FALL: begin
        if (!tick) begin
          state_s = ST_FALL;
        end else if (ny_s >= land_y_s) begin
          fall_y_s = land_y_s[9:0];
          state_s  = ST_LAND;
        end else begin
          fall_y_s = ny_s[9:0];
        end
      end
      ST_LAND: begin
        // slot 0 is the plate; the block lands one slot above the stack top
        fall_clr_s = CLR_NONE;
        if (catch_s) begin
          colors_s[{slot_s, 1'b0} +: 2] = fall_clr_r;
          height_s = slot_s;
          if (slot_s == MAX_H) begin
            win_s   = 1'b1;
            state_s = ST_FULL;
          end else begin
            state_s = ST_SPAWN;
          end
        end else begin
          misses_s = misses_r + 2'd1;
          if (misses_r == (MAX_MISS - 2'd1)) begin
            game_over_s = 1'b1;
            state_s     = ST_OVER;
          end else begin
            state_s = ST_SPAWN;
          end
        end
      end
      ST_OVER, ST_FULL: begin
        fall_clr_s = CLR_NONE;
        if (start) begin
          colors_s    = 32'd0;
          height_s    = 4'd0;
          misses_s    = 2'd0;
          game_over_s = 1'b0;
          win_s       = 1'b0;
          state_s     = ST_SPAWN;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      colors_r    <= 32'd0;
      fall_x_r    <= 10'd0;
      fall_y_r    <= 10'd0;
      fall_clr_r  <= CLR_NONE;
      height_r    <= 4'd0;
      misses_r    <= 2'd0;
      game_over_r <= 1'b0;
      win_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      colors_r    <= colors_s;
      fall_x_r    <= fall_x_s;
      fall_y_r    <= fall_y_s;
      fall_clr_r  <= fall_clr_s;
      height_r    <= height_s;
      misses_r    <= misses_s;
      game_over_r <= game_over_s;
      win_r       <= win_s;
    end
  end

  assign colors    = colors_r;
  assign fall_x    = fall_x_r;
  assign fall_y    = fall_y_r;
  assign fall_clr  = fall_clr_r;
  assign height    = height_r;
  assign misses    = misses_r;
  assign game_over = game_over_r;
  assign win       = win_r;

endmodule

// File: tb/tb_stack_engine.sv
// Randomized bench for stack_engine against a cycle-level game model built from plain integers.
module tb_stack_engine;

  logic        clk = 1'b0;
  logic        rst, tick, start;
  logic [9:0]  pos_x;
  logic [31:0] colors;
  logic [9:0]  fall_x, fall_y;
  logic [1:0]  fall_clr;
  logic [3:0]  height;
  logic [1:0]  misses;
  logic        game_over, win;

  stack_engine dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .pos_x(pos_x),
    .colors(colors), .fall_x(fall_x), .fall_y(fall_y), .fall_clr(fall_clr),
    .height(height), .misses(misses), .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  typedef enum int {P_IDLE, P_SPAWN, P_FALL, P_LAND, P_OVER, P_FULL} phase_t;
  phase_t m_phase = P_IDLE;
  int m_lfsr = 165, m_fx = 0, m_fy = 0, m_clr = 0, m_height = 0, m_misses = 0, m_over = 0, m_win = 0;
  int m_slot[16];
  int n_checks = 0, n_errors = 0;
`ifdef STACK_SPEEDUP_EN
  localparam int SPEEDUP = 1;
`else
  localparam int SPEEDUP = 0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lfsr_next(input int v);
    int fb;
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return ((v << 1) & 255) | fb;
  endfunction

  function automatic logic [31:0] model_colors();
    logic [31:0] c;
    c = 32'd0;
    for (int i = 0; i < 16; i++) c = c | (32'(m_slot[i]) << (2 * i));
    return c;
  endfunction

  function automatic logic [63:0] dut_vec();
    return {2'b00, colors, fall_x, fall_y, fall_clr, height, misses, game_over, win};
  endfunction

  function automatic logic [63:0] model_vec();
    return {2'b00, model_colors(), 10'(m_fx), 10'(m_fy), 2'(m_clr), 4'(m_height),
            2'(m_misses), 1'(m_over), 1'(m_win)};
  endfunction

  task automatic model_clear_game();
    for (int i = 0; i < 16; i++) m_slot[i] = 0;
    m_height = 0; m_misses = 0; m_over = 0; m_win = 0;
  endtask

  task automatic model_step();
    int d, step, ny, land;
    if (rst) begin
      model_clear_game();
      m_fx = 0; m_fy = 0; m_clr = 0; m_phase = P_IDLE; m_lfsr = 165;
    end else begin
      case (m_phase)
        P_IDLE: if (start) m_phase = P_SPAWN;
        P_SPAWN: begin
          m_fx = m_lfsr * 2;
          m_clr = (m_lfsr % 4 == 0) ? 2 : m_lfsr % 4;
          m_fy = 20;
          m_phase = P_FALL;
        end
        P_FALL: if (tick) begin
          step = 4 + SPEEDUP * (m_height / 4);
          ny = m_fy + step;
          land = 400 - (m_height + 1) * 20;
          if (ny >= land) begin m_fy = land; m_phase = P_LAND; end
          else m_fy = ny;
        end
        P_LAND: begin
          d = m_fx - int'(pos_x);
          if (d < 0) d = -d;
          if (d < 50) begin
            m_slot[m_height + 1] = m_clr;
            m_height++;
            if (m_height == 15) begin m_win = 1; m_phase = P_FULL; end
            else m_phase = P_SPAWN;
          end else begin
            m_misses++;
            if (m_misses == 3) begin m_over = 1; m_phase = P_OVER; end
            else m_phase = P_SPAWN;
          end
          m_clr = 0;
        end
        default: begin
          m_clr = 0;
          if (start) begin model_clear_game(); m_phase = P_SPAWN; end
        end
      endcase
      m_lfsr = lfsr_next(m_lfsr);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("cycle", dut_vec(), model_vec());
  endtask

  task automatic wait_phase(input phase_t p, input int budget);
    int n = 0;
    while (m_phase != p && n < budget) begin cycle(); n++; end
    if (m_phase != p) check("timeout_phase", 64'd0, 64'd1);
  endtask

  // Drop one block and steer the plate to catch or miss it.
  task automatic play_block(input bit catch_it, input bit speed_check, input int density,
                            input bit noisy_start, output int land_at);
    int px, n, prev;
    land_at = -1;
    wait_phase(P_FALL, 10);
    if (catch_it) begin
      px = m_fx + $urandom_range(0, 98) - 49;
      if (px < 0) px = 0;
    end else begin
      px = m_fx + 60 + $urandom_range(0, 400);
    end
    pos_x = 10'(px);
    if (speed_check) begin
      prev = int'(fall_y);
      tick = 1'b1; cycle(); tick = 1'b0;
      check("step_size", 64'(int'(fall_y) - prev), 64'(4 + SPEEDUP));
    end
    n = 0;
    while (m_phase == P_FALL && n < 2000) begin
      tick = ($urandom_range(0, 99) < density);
      start = noisy_start && ($urandom_range(0, 49) == 0);
      cycle(); n++;
    end
    tick = 1'b0; start = 1'b0;
    if (m_phase != P_LAND) begin
      check("timeout_fall", 64'd0, 64'd1);
    end else begin
      land_at = int'(fall_y);
      check("land_y", 64'(fall_y), 64'(400 - (m_height + 1) * 20));
      cycle();
    end
  endtask

  initial begin
    int nt, land_at;
    logic [31:0] saved_c;
    logic [9:0] saved_y;
    rst = 1'b1; tick = 1'b0; start = 1'b0; pos_x = 10'd0;
    for (int i = 0; i < 16; i++) m_slot[i] = 0;
    cycle(); cycle();
    check("reset", dut_vec(), 64'd0);
    rst = 1'b0;
    cycle();

    // reset in the middle of a fall
    start = 1'b1; tick = 1'b1; cycle(); start = 1'b0; tick = 1'b0;
    wait_phase(P_FALL, 10);
    nt = 0;
    while (m_fy < 100 && nt < 40) begin tick = 1'b1; cycle(); nt++; end
    tick = 1'b0;
    check("fy_100", 64'(fall_y), 64'd100);
    rst = 1'b1; cycle(); rst = 1'b0;
    check("rst_mid_fall", dut_vec(), 64'd0);

    // first catch: 90 ticks to land at 380
    start = 1'b1; cycle(); start = 1'b0;
    wait_phase(P_FALL, 10);
    pos_x = 10'(m_fx);
    nt = 0;
    while (m_phase == P_FALL && nt < 200) begin tick = 1'b1; cycle(); nt++; end
    tick = 1'b0;
    check("ticks_90", 64'(nt), 64'd90);
    check("land_380", 64'(fall_y), 64'd380);
    saved_y = 10'(m_clr);
    cycle();
    check("slot1_clr", 64'(colors[3:2]), 64'(saved_y[1:0]));
    check("slot1_nonzero", 64'(colors[3:2] != 2'b00), 64'd1);
    check("height_1", 64'(height), 64'd1);
    check("clr_gone", 64'(fall_clr), 64'd0);

    // miss, then respawn
    saved_c = colors;
    play_block(1'b0, 1'b0, 70, 1'b0, land_at);
    check("miss_1", 64'(misses), 64'd1);
    check("miss_colors", 64'(colors), 64'(saved_c));
    wait_phase(P_FALL, 10);
    check("respawn_y", 64'(fall_y), 64'd20);

    // game over after three misses
    play_block(1'b0, 1'b0, 70, 1'b1, land_at);
    play_block(1'b0, 1'b0, 70, 1'b0, land_at);
    check("game_over", 64'(game_over), 64'd1);
    check("over_clr", 64'(fall_clr), 64'd0);
    saved_y = fall_y;
    tick = 1'b1; for (int i = 0; i < 5; i++) cycle(); tick = 1'b0;
    check("over_tick_ignored", 64'(fall_y), 64'(saved_y));
    check("over_held", 64'(game_over), 64'd1);
    start = 1'b1; cycle(); start = 1'b0;
    check("restart_clear", 64'({colors, height, misses, game_over, win}), 64'd0);

    // fill the stack, checking fall speed at height 4
    for (int i = 0; i < 15; i++) play_block(1'b1, i == 4, 60, 1'b0, land_at);
    check("land_100", 64'(land_at), 64'd100);
    check("height_15", 64'(height), 64'd15);
    check("win", 64'(win), 64'd1);
    check("slot15_set", 64'(colors[31:30] != 2'b00), 64'd1);
    check("slot0_empty", 64'(colors[1:0]), 64'd0);
    check("full_clr", 64'(fall_clr), 64'd0);
    tick = 1'b1; cycle(); cycle(); tick = 1'b0;
    check("full_held", 64'(win), 64'd1);
    start = 1'b1; cycle(); start = 1'b0;
    check("full_restart", 64'({colors, height, win}), 64'd0);

    // random play
    for (int b = 0; b < 40; b++) begin
      if (m_phase == P_OVER || m_phase == P_FULL) begin
        for (int k = 0; k < int'($urandom_range(0, 3)); k++) cycle();
        start = 1'b1; cycle(); start = 1'b0;
      end
      play_block($urandom_range(0, 2) != 0, 1'b0, $urandom_range(20, 100), 1'b1, land_at);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
